// File: rtl/fft_2d_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_2d_seq_ctrl_pkg
// Shared definitions for the 4x4 two-pass 2D FFT sequencer: the input-select
// bus type and its codes, the controller state encodings, the reset-enable
// level, and the state-to-select decode used by the controller.
// -----------------------------------------------------------------------------
package fft_2d_seq_ctrl_pkg;

    // Input-selection bus: which source feeds the FFT core.
    typedef logic [2:0] sel_bus_t;

    localparam sel_bus_t SEL_ORIG = 3'd0;  // original input frame
    localparam sel_bus_t SEL_RT   = 3'd1;  // data returned from the row pass

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Level of the reset input that forces the controller to IDLE.
    localparam logic RESET_ACTIVE = 1'b1;

    // Column pass and the finished frame both look at the returned data.
    function automatic sel_bus_t state_sel(input state_t st);
        return (st == ST_COL || st == ST_DONE) ? SEL_RT : SEL_ORIG;
    endfunction

endpackage

// File: rtl/fft_2d_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_2d_seq_ctrl_if
// Handshake and strobe bundle between the FFT sequencer and its surroundings.
//   in_valid/in_ready   : frame handshake from upstream
//   in_ld_en            : input frame register bank load strobe
//   sel                 : input-selection code for the core
//   core_en             : FFT core enable
//   rt_ld_en            : returned-data register bank capture strobe
//   out_valid/out_ready : finished frame handshake to downstream
//   flush               : synchronous abort to IDLE
//   busy                : controller not in IDLE
//   frame_cnt           : completed-frame counter
// Modports: master = surrounding logic, slave = sequencer.
// -----------------------------------------------------------------------------
interface fft_2d_seq_ctrl_if
    import fft_2d_seq_ctrl_pkg::*;
#(
    parameter int FCNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_ld_en;
    sel_bus_t          sel;
    logic              core_en;
    logic              rt_ld_en;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output in_valid, out_ready, flush,
        input  in_ready, in_ld_en, sel, core_en, rt_ld_en, out_valid, busy, frame_cnt
    );

    modport slave (
        input  in_valid, out_ready, flush,
        output in_ready, in_ld_en, sel, core_en, rt_ld_en, out_valid, busy, frame_cnt
    );
endinterface

// File: rtl/fft_2d_seq_ctrl_lat_cnt.sv
// -----------------------------------------------------------------------------
// fft_lat_cnt
// Loadable down-counter that times one FFT core pass. Shared by the row and
// column passes.
//   clk, reset : clock, synchronous reset (level RESET_ACTIVE)
//   clr        : synchronous clear to 0 (abort)
//   load       : load load_val (takes priority over en)
//   load_val   : value to load
//   en         : decrement by one
//   zero       : counter currently holds 0
// -----------------------------------------------------------------------------
module fft_lat_cnt
    import fft_2d_seq_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/fft_2d_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_2d_seq_ctrl
// Sequencer for the 4x4 two-pass 2D FFT datapath. Accepts one frame, runs a
// row pass on the original inputs (sel=0) and a column pass on the returned
// data (sel=1), each lasting CORE_LAT cycles, strobes capture of the row-pass
// result, then holds the finished frame until downstream accepts it.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : handshake/strobe bundle (slave side)
// Parameters:
//   CORE_LAT : FFT core latency per pass, 1..15
//   FCNT_W   : completed-frame counter width
// -----------------------------------------------------------------------------
module fft_2d_seq_ctrl
    import fft_2d_seq_ctrl_pkg::*;
#(
    parameter int CORE_LAT = 2,
    parameter int FCNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    fft_2d_seq_ctrl_if.slave    bus
);
    if (CORE_LAT < 1 || CORE_LAT > 15) begin : g_bad_core_lat
        $error("fft_2d_seq_ctrl: CORE_LAT must be in 1..15");
    end

    localparam int          LW       = $clog2(CORE_LAT + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(CORE_LAT - 1);

    state_t            state, state_nxt;
    logic              in_rst;
    logic              cnt_clr, cnt_load, cnt_en, cnt_zero;
    logic              frame_inc;
    logic [FCNT_W-1:0] frame_cnt;

    assign in_rst = (reset == RESET_ACTIVE);

    fft_lat_cnt #(.W(LW)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        frame_inc = 1'b0;

        // Abort wins over any pending transition, including a DONE handshake.
        if (bus.flush && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_ld_en) begin
                        state_nxt = ST_ROW;
                        cnt_load  = 1'b1;
                    end
                end
                ST_ROW: begin
                    if (cnt_zero) begin
                        state_nxt = ST_COL;
                        cnt_load  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_COL: begin
                    if (cnt_zero) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = ST_IDLE;
                        frame_inc = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            frame_cnt <= '0;
        end else if (frame_inc) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // State-decoded outputs; all forced low while reset is asserted so a
    // frame abandoned by reset never presents out_valid or a strobe.
    assign bus.in_ready  = (state == ST_IDLE) & ~in_rst;
    assign bus.in_ld_en  = bus.in_valid & bus.in_ready;
    assign bus.sel       = in_rst ? SEL_ORIG : state_sel(state);
    assign bus.core_en   = ~in_rst & (state == ST_ROW || state == ST_COL);
    assign bus.out_valid = ~in_rst & (state == ST_DONE);
    assign bus.busy      = ~in_rst & (state != ST_IDLE);
    // Last row-pass cycle: row results are valid at the core output.
    assign bus.rt_ld_en  = ~in_rst & (state == ST_ROW) & cnt_zero;
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_fft_2d_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_2d_seq_ctrl
// Directed bench for the FFT sequencer. Two instances: u0 (CORE_LAT=2,
// FCNT_W=16) for the main timing, backpressure, flush and reset cases, and
// u1 (CORE_LAT=1, FCNT_W=4) for the short-latency case and counter wrap.
// Each stimulus cycle pushes the hand-computed output vector for that cycle;
// a monitor per instance pops and compares on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_2d_seq_ctrl;
    import fft_2d_seq_ctrl_pkg::*;

    typedef struct packed {
        logic        in_ready;
        logic        in_ld_en;
        logic [2:0]  sel;
        logic        core_en;
        logic        rt_ld_en;
        logic        out_valid;
        logic        busy;
        logic [15:0] fc;
    } vec_t;

    typedef struct {
        vec_t  v;
        bit    fc_care;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   failures = 0;
    int   rt1_cnt = 0;
    int   hs1_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    vec_t g0, g1;

    always #5 clk = ~clk;

    fft_2d_seq_ctrl_if #(.FCNT_W(16)) ifc0 ();
    fft_2d_seq_ctrl_if #(.FCNT_W(4))  ifc1 ();

    fft_2d_seq_ctrl #(.CORE_LAT(2), .FCNT_W(16)) u0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (ifc0)
    );

    fft_2d_seq_ctrl #(.CORE_LAT(1), .FCNT_W(4)) u1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (ifc1)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic ld, input logic [2:0] s,
                                input logic ce, input logic rt, input logic ov,
                                input logic bz, input logic [15:0] fc);
        vec_t v;
        v.in_ready = ir; v.in_ld_en = ld; v.sel = s; v.core_en = ce;
        v.rt_ld_en = rt; v.out_valid = ov; v.busy = bz; v.fc = fc;
        return v;
    endfunction

    function automatic vec_t v_idle(input logic [15:0] fc); return mk(1, 0, 3'd0, 0, 0, 0, 0, fc); endfunction
    function automatic vec_t v_hs(input logic [15:0] fc);   return mk(1, 1, 3'd0, 0, 0, 0, 0, fc); endfunction
    function automatic vec_t v_row(input logic rt, input logic [15:0] fc); return mk(0, 0, 3'd0, 1, rt, 0, 1, fc); endfunction
    function automatic vec_t v_col(input logic [15:0] fc);  return mk(0, 0, 3'd1, 1, 0, 0, 1, fc); endfunction
    function automatic vec_t v_done(input logic [15:0] fc); return mk(0, 0, 3'd1, 0, 0, 1, 1, fc); endfunction
    function automatic vec_t v_zero(input logic [15:0] fc); return mk(0, 0, 3'd0, 0, 0, 0, 0, fc); endfunction

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that same cycle.
    task automatic step(input int d, input logic iv, input logic orr, input logic fl,
                        input logic rs, input vec_t v, input bit care, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (d == 0) begin
            ifc0.in_valid = iv; ifc0.out_ready = orr; ifc0.flush = fl; rst0 = rs;
        end else begin
            ifc1.in_valid = iv; ifc1.out_ready = orr; ifc1.flush = fl; rst1 = rs;
        end
        e.v = v; e.fc_care = care; e.nm = nm;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            g0 = {ifc0.in_ready, ifc0.in_ld_en, ifc0.sel, ifc0.core_en, ifc0.rt_ld_en,
                  ifc0.out_valid, ifc0.busy, ifc0.frame_cnt};
            if (e0.fc_care) check(e0.nm, 32'(g0), 32'(e0.v));
            else            check(e0.nm, 32'(g0[23:16]), 32'(e0.v[23:16]));
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            g1 = {ifc1.in_ready, ifc1.in_ld_en, ifc1.sel, ifc1.core_en, ifc1.rt_ld_en,
                  ifc1.out_valid, ifc1.busy, 12'd0, ifc1.frame_cnt};
            if (e1.fc_care) check(e1.nm, 32'(g1), 32'(e1.v));
            else            check(e1.nm, 32'(g1[23:16]), 32'(e1.v[23:16]));
        end
    end

    always @(negedge clk) begin
        if (ifc1.rt_ld_en) rt1_cnt++;
        if (ifc1.in_valid && ifc1.in_ready) hs1_cnt++;
    end

    initial begin
        int  base_rt, base_hs;
        bit  done;

        rst0 = 1'b1; rst1 = 1'b1;
        ifc0.in_valid = 1'b0; ifc0.out_ready = 1'b0; ifc0.flush = 1'b0;
        ifc1.in_valid = 1'b0; ifc1.out_ready = 1'b0; ifc1.flush = 1'b0;

        // ---------------- u0: CORE_LAT=2 ----------------
        step(0, 0, 0, 0, 1, v_zero(0), 1, "u0_reset");
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, v_idle(0), 1, "u0_idle");

        // Single frame, out_ready high throughout (ignored outside DONE).
        step(0, 1, 1, 0, 0, v_hs(0),      1, "f1_t0_hs");
        step(0, 0, 1, 0, 0, v_row(0, 0),  1, "f1_t1_row");
        step(0, 0, 1, 0, 0, v_row(1, 0),  1, "f1_t2_row_rt");
        step(0, 0, 1, 0, 0, v_col(0),     1, "f1_t3_col");
        step(0, 0, 1, 0, 0, v_col(0),     1, "f1_t4_col");
        step(0, 0, 1, 0, 0, v_done(0),    1, "f1_t5_done");
        step(0, 0, 1, 0, 0, v_idle(1),    1, "f1_t6_idle");

        // Backpressure, in_valid held high while busy.
        step(0, 1, 0, 0, 0, v_hs(1),      1, "f2_t0_hs");
        step(0, 1, 0, 0, 0, v_row(0, 1),  1, "f2_t1_row");
        step(0, 1, 0, 0, 0, v_row(1, 1),  1, "f2_t2_row_rt");
        step(0, 1, 0, 0, 0, v_col(1),     1, "f2_t3_col");
        step(0, 1, 0, 0, 0, v_col(1),     1, "f2_t4_col");
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, v_done(1), 1, "f2_bp_hold");
        step(0, 1, 1, 0, 0, v_done(1),    1, "f2_bp_release");

        // Frame accepted right away, then flushed in COL.
        step(0, 1, 0, 0, 0, v_hs(2),      1, "f3_t0_hs");
        step(0, 0, 0, 0, 0, v_row(0, 2),  1, "f3_t1_row");
        step(0, 0, 0, 0, 0, v_row(1, 2),  1, "f3_t2_row_rt");
        step(0, 0, 0, 1, 0, v_col(2),     1, "f3_t3_flush_col");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, v_idle(2), 1, "f3_after_flush");

        // Flush in IDLE with in_valid: accepted normally; then reset in ROW.
        step(0, 1, 0, 1, 0, v_hs(2),      1, "idle_flush_hs");
        step(0, 0, 0, 0, 0, v_row(0, 2),  1, "f4_t1_row");
        step(0, 0, 0, 0, 1, v_zero(0),    0, "f4_reset_in_row");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, v_idle(0), 1, "f4_after_reset");

        // ---------------- u1: CORE_LAT=1, FCNT_W=4 ----------------
        step(1, 0, 0, 0, 1, v_zero(0),    1, "u1_reset");
        step(1, 0, 0, 0, 0, v_idle(0),    1, "u1_idle");
        step(1, 1, 0, 0, 0, v_hs(0),      1, "u1_t0_hs");
        step(1, 0, 0, 0, 0, v_row(1, 0),  1, "u1_t1_row_rt");
        step(1, 0, 0, 0, 0, v_col(0),     1, "u1_t2_col");
        step(1, 0, 1, 1, 0, v_done(0),    1, "u1_t3_flush_and_ready");
        step(1, 0, 0, 0, 0, v_idle(0),    1, "u1_t4_idle");

        // Back-to-back: 70 frames with out_ready high; 70 mod 16 = 6.
        base_rt = rt1_cnt;
        base_hs = hs1_cnt;
        done    = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(posedge clk);
            #1;
            ifc1.out_ready = 1'b1;
            ifc1.in_valid  = ((hs1_cnt - base_hs) < 70);
            if ((hs1_cnt - base_hs) == 70 && !ifc1.busy) done = 1'b1;
        end
        if (!done) check("b2b_timeout", 32'(hs1_cnt - base_hs), 32'd70);
        step(1, 0, 1, 0, 0, v_idle(6),    1, "u1_wrap_frame_cnt");
        check("u1_rt_pulses", 32'(rt1_cnt - base_rt), 32'd70);
        check("u1_handshakes", 32'(hs1_cnt - base_hs), 32'd70);

        @(negedge clk);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
